// File: rtl/arena_life_engine.sv
// Double-buffered Conway arena with sequential one-cell-per-clock generation engine.
// Optional build macro ARENA_TORUS_EN: neighbour coordinates wrap toroidally.
module arena_life_engine #(
    parameter int unsigned ARENA_WIDTH  = 10,
    parameter int unsigned ARENA_HEIGHT = 10,
    parameter int unsigned GEN_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [9:0]           arena_row_select,
    input  logic [9:0]           arena_column_select,
    output logic                 arena_cell_value,
    input  logic                 step_req,
    input  logic                 seed_valid,
    input  logic [9:0]           seed_row,
    input  logic [9:0]           seed_column,
    input  logic                 seed_value,
    input  logic                 clear_req,
    output logic                 busy,
    output logic [GEN_WIDTH-1:0] generation
);

    localparam int unsigned CELLS = ARENA_WIDTH * ARENA_HEIGHT;
    localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned CW    = 11;
    localparam logic [CW-1:0] W_L = CW'(ARENA_WIDTH);
    localparam logic [CW-1:0] H_L = CW'(ARENA_HEIGHT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPUTE,
        ST_SWAP
    } state_t;

    state_t state_q, state_d;

    logic [CELLS-1:0] bank0, bank1;
    logic             front_sel;
    logic [CW-1:0]    scan_r, scan_c;

    logic [CELLS-1:0] front_c;
    logic             seed_we_c, clear_c, scan_last_c;
    logic [CW-1:0]    rm_c, rp_c, cm_c, cp_c;
    logic [3:0]       n_c;
    logic             next_cell_c;

    function automatic logic in_range(input logic [CW-1:0] r, input logic [CW-1:0] c);
        return (r < H_L) && (c < W_L);
    endfunction

    function automatic logic [IDX_W-1:0] cell_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
        int unsigned i;
        i = 32'(r) * ARENA_WIDTH + 32'(c);
        return IDX_W'(i);
    endfunction

    // Out-of-arena coordinates (including the all-ones wrap of 0-1) read as dead.
    function automatic logic cell_at(input logic [CELLS-1:0] bank,
                                     input logic [CW-1:0] r, input logic [CW-1:0] c);
        return in_range(r, c) ? bank[cell_idx(r, c)] : 1'b0;
    endfunction

    assign front_c = front_sel ? bank1 : bank0;

    // Neighbour coordinates of the scan cell
    always_comb begin
`ifdef ARENA_TORUS_EN
        rm_c = (scan_r == '0) ? H_L - CW'(1) : scan_r - CW'(1);
        rp_c = (scan_r == H_L - CW'(1)) ? '0 : scan_r + CW'(1);
        cm_c = (scan_c == '0) ? W_L - CW'(1) : scan_c - CW'(1);
        cp_c = (scan_c == W_L - CW'(1)) ? '0 : scan_c + CW'(1);
`else
        rm_c = scan_r - CW'(1);
        rp_c = scan_r + CW'(1);
        cm_c = scan_c - CW'(1);
        cp_c = scan_c + CW'(1);
`endif
    end

    always_comb begin
        n_c = 4'(cell_at(front_c, rm_c,   cm_c))   + 4'(cell_at(front_c, rm_c,   scan_c))
            + 4'(cell_at(front_c, rm_c,   cp_c))   + 4'(cell_at(front_c, scan_r, cm_c))
            + 4'(cell_at(front_c, scan_r, cp_c))   + 4'(cell_at(front_c, rp_c,   cm_c))
            + 4'(cell_at(front_c, rp_c,   scan_c)) + 4'(cell_at(front_c, rp_c,   cp_c));
        next_cell_c = (n_c == 4'd3) | (cell_at(front_c, scan_r, scan_c) & (n_c == 4'd2));
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next state and control strobes
    always_comb begin
        state_d     = state_q;
        seed_we_c   = 1'b0;
        clear_c     = 1'b0;
        scan_last_c = (scan_r == H_L - CW'(1)) && (scan_c == W_L - CW'(1));
        case (state_q)
            ST_IDLE: begin
                clear_c   = clear_req;
                seed_we_c = seed_valid & ~clear_req & in_range({1'b0, seed_row}, {1'b0, seed_column});
                if (step_req) state_d = ST_COMPUTE;
            end
            ST_COMPUTE: begin
                if (scan_last_c) state_d = ST_SWAP;
            end
            ST_SWAP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Banks, scan index, read port and status outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank0            <= '0;
            bank1            <= '0;
            front_sel        <= 1'b0;
            scan_r           <= '0;
            scan_c           <= '0;
            generation       <= '0;
            busy             <= 1'b0;
            arena_cell_value <= 1'b0;
        end else begin
            arena_cell_value <= cell_at(front_c, {1'b0, arena_row_select}, {1'b0, arena_column_select});
            busy             <= (state_d != ST_IDLE);

            if (clear_c) begin
                if (front_sel) bank1 <= '0;
                else           bank0 <= '0;
            end else if (seed_we_c) begin
                if (front_sel) bank1[cell_idx({1'b0, seed_row}, {1'b0, seed_column})] <= seed_value;
                else           bank0[cell_idx({1'b0, seed_row}, {1'b0, seed_column})] <= seed_value;
            end

            if (state_q == ST_COMPUTE) begin
                if (front_sel) bank0[cell_idx(scan_r, scan_c)] <= next_cell_c;
                else           bank1[cell_idx(scan_r, scan_c)] <= next_cell_c;
                if (scan_c == W_L - CW'(1)) begin
                    scan_c <= '0;
                    scan_r <= scan_last_c ? '0 : scan_r + CW'(1);
                end else begin
                    scan_c <= scan_c + CW'(1);
                end
            end

            if (state_q == ST_SWAP) begin
                front_sel  <= ~front_sel;
                generation <= generation + GEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_arena_life_engine.sv
// Self-checking bench for arena_life_engine: Life model plus read-port scoreboard.
module tb_arena_life_engine;

    localparam int W = 10;
    localparam int H = 10;
    localparam int GW = 16;
    localparam int BUSY_LEN = W * H + 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [9:0]    arena_row_select = '0;
    logic [9:0]    arena_column_select = '0;
    logic          arena_cell_value;
    logic          step_req = 1'b0;
    logic          seed_valid = 1'b0;
    logic [9:0]    seed_row = '0;
    logic [9:0]    seed_column = '0;
    logic          seed_value = 1'b0;
    logic          clear_req = 1'b0;
    logic          busy;
    logic [GW-1:0] generation;

    arena_life_engine #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H), .GEN_WIDTH(GW)) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .arena_row_select    (arena_row_select),
        .arena_column_select (arena_column_select),
        .arena_cell_value    (arena_cell_value),
        .step_req            (step_req),
        .seed_valid          (seed_valid),
        .seed_row            (seed_row),
        .seed_column         (seed_column),
        .seed_value          (seed_value),
        .clear_req           (clear_req),
        .busy                (busy),
        .generation          (generation)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int c;
        bit v;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    bit      mdl[H][W];
    int      gen_exp = 0;
    int      checks = 0;
    int      errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic bit mget(input int r, input int c);
`ifdef ARENA_TORUS_EN
        r = (r + H) % H;
        c = (c + W) % W;
`else
        if (r < 0 || r >= H || c < 0 || c >= W) return 1'b0;
`endif
        return mdl[r][c];
    endfunction

    function automatic void model_step();
        bit nxt[H][W];
        int n;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += int'(mget(r + dr, c + dc));
                nxt[r][c] = (n == 3) || (mdl[r][c] && n == 2);
            end
        mdl = nxt;
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) mdl[r][c] = 1'b0;
    endfunction

    function automatic bit exp_cell(input int r, input int c);
        if (r >= H || c >= W) return 1'b0;
        return mdl[r][c];
    endfunction

    // Each negedge: retire the address driven one cycle earlier, then drive a new one.
    task automatic push_read(input int r, input int c);
        rd_exp_t e;
        @(negedge clk);
        if (rd_q.size() > 0) begin
            e = rd_q.pop_front();
            check_eq($sformatf("cell_%0d_%0d", e.r, e.c), 32'(arena_cell_value), 32'(e.v));
        end
        arena_row_select    = 10'(r);
        arena_column_select = 10'(c);
        rd_q.push_back('{r: r, c: c, v: exp_cell(r, c)});
    endtask

    task automatic drain_reads();
        rd_exp_t e;
        while (rd_q.size() > 0) begin
            @(negedge clk);
            e = rd_q.pop_front();
            check_eq($sformatf("cell_%0d_%0d", e.r, e.c), 32'(arena_cell_value), 32'(e.v));
        end
    endtask

    task automatic scan_arena();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) push_read(r, c);
        drain_reads();
    endtask

    task automatic seed_cell(input int r, input int c, input bit v);
        @(negedge clk);
        seed_valid  = 1'b1;
        seed_row    = 10'(r);
        seed_column = 10'(c);
        seed_value  = v;
        @(negedge clk);
        seed_valid  = 1'b0;
        if (r < H && c < W) mdl[r][c] = v;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        model_clear();
    endtask

    task automatic wait_busy_low(output int cnt);
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        if (cnt >= 2000) check_eq("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic do_step();
        int cnt;
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        wait_busy_low(cnt);
        check_eq("busy_len", 32'(cnt), 32'(BUSY_LEN));
        model_step();
        gen_exp++;
        check_eq("generation", 32'(generation), 32'(gen_exp));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        gen_exp = 0;
    endtask

    initial begin
        int cnt;
        model_clear();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Reset state
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_gen", 32'(generation), 32'd0);
        push_read(0, 0);
        push_read(9, 9);
        push_read(10, 0);
        push_read(0, 10);
        drain_reads();

        // Blinker oscillates
        seed_cell(5, 4, 1'b1);
        seed_cell(5, 5, 1'b1);
        seed_cell(5, 6, 1'b1);
        seed_cell(12, 3, 1'b1);
        scan_arena();
        do_step();
        check_eq("blinker_v45", 32'(mdl[4][5]), 32'd1);
        scan_arena();
        do_step();
        scan_arena();

        // Clear wins over a simultaneous seed write
        @(negedge clk);
        clear_req   = 1'b1;
        seed_valid  = 1'b1;
        seed_row    = 10'd3;
        seed_column = 10'd3;
        seed_value  = 1'b1;
        @(negedge clk);
        clear_req   = 1'b0;
        seed_valid  = 1'b0;
        model_clear();
        scan_arena();

        // Still-life block after a fresh reset
        do_reset();
        seed_cell(0, 0, 1'b1);
        seed_cell(0, 1, 1'b1);
        seed_cell(1, 0, 1'b1);
        seed_cell(1, 1, 1'b1);
        repeat (3) do_step();
        check_eq("block_gen", 32'(generation), 32'd3);
        scan_arena();

        // Glider at the bottom-right corner
        do_clear();
        seed_cell(7, 8, 1'b1);
        seed_cell(8, 9, 1'b1);
        seed_cell(9, 7, 1'b1);
        seed_cell(9, 8, 1'b1);
        seed_cell(9, 9, 1'b1);
        repeat (4) do_step();
        scan_arena();

        // Requests while busy are dropped
        do_clear();
        seed_cell(5, 4, 1'b1);
        seed_cell(5, 5, 1'b1);
        seed_cell(5, 6, 1'b1);
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (10) @(negedge clk);
        step_req    = 1'b1;
        seed_valid  = 1'b1;
        seed_row    = 10'd2;
        seed_column = 10'd2;
        seed_value  = 1'b1;
        clear_req   = 1'b1;
        @(negedge clk);
        step_req    = 1'b0;
        seed_valid  = 1'b0;
        clear_req   = 1'b0;
        wait_busy_low(cnt);
        check_eq("busy_len_ign", 32'(cnt + 11), 32'(BUSY_LEN));
        model_step();
        gen_exp++;
        check_eq("gen_ign", 32'(generation), 32'(gen_exp));
        repeat (5) @(negedge clk);
        check_eq("no_queued_busy", 32'(busy), 32'd0);
        check_eq("no_queued_gen", 32'(generation), 32'(gen_exp));
        scan_arena();

        // Reset in the middle of COMPUTE
        @(negedge clk);
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
        repeat (50) @(negedge clk);
        check_eq("mid_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_gen", 32'(generation), 32'd0);
        check_eq("abort_cell", 32'(arena_cell_value), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_clear();
        gen_exp = 0;
        repeat (3) @(negedge clk);
        check_eq("post_rst_busy", 32'(busy), 32'd0);
        check_eq("post_rst_gen", 32'(generation), 32'd0);
        scan_arena();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arena_life_engine.md
Name: arena_life_engine

Overview:
- Upstream stage of the VGA image renderer: holds the Conway arena and answers its per-pixel cell lookups.
- Double-buffered cell storage. The display reads the front bank while a sequential engine writes the next generation into the back bank, one cell per clock.
- Banks swap atomically at the end of a generation, so the display never sees a half-computed arena.
- A seed port loads the initial pattern while the engine is idle.

Parameters:
- ARENA_WIDTH, 10, number of cell columns (1..1023).
- ARENA_HEIGHT, 10, number of cell rows (1..1023).
- GEN_WIDTH, 16, width of the generation counter.

Ports:
- clk  input  1  single clock; also drives the display read port (renderer's arena_clk connects here).
- reset_n  input  1  asynchronous, active-low reset.
- arena_row_select  input  10  display read row.
- arena_column_select  input  10  display read column.
- arena_cell_value  output  1  front-bank cell at the selected address, registered.
- step_req  input  1  single-cycle request to compute one generation.
- seed_valid  input  1  seed write strobe.
- seed_row  input  10  seed write row.
- seed_column  input  10  seed write column.
- seed_value  input  1  seed write data.
- clear_req  input  1  clear the front bank.
- busy  output  1  high while a generation is being computed.
- generation  output  GEN_WIDTH  count of completed generations.

Behaviour:
- Reset: asynchronous, active-low.
  - Both banks cleared, front-bank select = 0, state IDLE.
  - busy = 0, generation = 0, arena_cell_value = 0.
- Display read port:
  - arena_cell_value <= front[row][col] on every clk edge; latency 1 cycle.
  - An address with row >= ARENA_HEIGHT or column >= ARENA_WIDTH returns 0.
  - The read port is never stalled, including while busy.
- State machine IDLE -> COMPUTE -> SWAP -> IDLE.
  - IDLE: accepts seed_valid, clear_req and step_req.
  - Seed write: when seed_valid = 1 and the address is in range, write seed_value to the front bank. Out-of-range writes are dropped.
  - clear_req = 1 zeroes the entire front bank in one cycle. If clear_req and seed_valid arrive together, the clear wins.
  - step_req = 1 moves to COMPUTE on the next edge. A seed write or clear in the same cycle is applied first, so the computation sees it.
  - COMPUTE: a scan index walks row-major from (0,0) to (H-1,W-1), one cell per cycle, so the state lasts exactly W*H cycles.
    - Each cycle: count the 8 neighbours of the current cell in the front bank (0..8, 4-bit sum).
    - back[cell] = (n == 3) | (front[cell] & n == 2).
    - Neighbours outside the arena count as dead (see Optional Feature).
  - SWAP: 1 cycle. Toggle the front-bank select and increment generation (wraps modulo 2^GEN_WIDTH), then return to IDLE.
- busy is high in COMPUTE and SWAP. It goes high the cycle after step_req is accepted and goes low in the same cycle the generation increments.
- Total step latency: W*H + 1 cycles from the accepting edge to the new front bank being visible. The first read reflecting the new generation comes one cycle later.
- While busy, step_req, seed_valid and clear_req are ignored; there is no queuing.
- Reset during COMPUTE or SWAP aborts the step and restores the full reset state; no partial generation survives.
- The engine never writes the front bank, and the display never reads the back bank.

Optional Feature:
- Macro ARENA_TORUS_EN.
- Defined: neighbour coordinates wrap toroidally. Column -1 maps to W-1 and column W maps to 0; rows likewise.
- Undefined: out-of-arena neighbours read as 0, and there is no wrap logic in the design.
- The read port and timing are identical in both builds.

Test Plan:
- Reset, then read (0,0), (9,9) and (10,0) -> arena_cell_value = 0 for all; busy = 0; generation = 0.
- Seed horizontal blinker at (5,4),(5,5),(5,6), then pulse step_req.
  - busy stays high for exactly 101 cycles; generation = 1.
  - Live cells are then exactly (4,5),(5,5),(6,5).
  - A second step restores the horizontal blinker; generation = 2.
- Seed 2x2 block at (0,0)..(1,1) and step 3 times -> the pattern is unchanged and generation = 3.
- Seed glider at the bottom-right corner and step 4 times.
  - Without ARENA_TORUS_EN: cells die at the edge with no wrap.
  - With ARENA_TORUS_EN: the glider reappears shifted by one cell diagonally, wrapped to row/column 0.
- Pulse step_req, then during busy pulse step_req, seed_valid to (2,2)=1 and clear_req.
  - No effect: cell (2,2) keeps its computed value and generation increments by exactly 1.
- Deassert reset_n at scan index 50 of COMPUTE -> immediate busy = 0, generation = 0, all reads return 0.
